// File: rtl/mul_arb_pkg.sv
// Shared types and constants for the two-requester multiplier arbiter.
// Optional round-robin build is selected with MUL_ARB_RR_EN.
package mul_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  localparam int unsigned MUL_CYCLES_DEFAULT = 32;
  localparam int unsigned CNT_W              = 6;

endpackage

// File: rtl/mul_arb_rr.sv
// Two-way grant logic: one-hot grant from two requests and the last-granted id.
// MUL_ARB_RR_EN selects round-robin; otherwise req0 has fixed priority.
module mul_arb_rr (
  input  logic [1:0] i_req,
  input  logic       i_last,
  output logic [1:0] o_grant
);

`ifdef MUL_ARB_RR_EN
  always_comb begin
    o_grant = '0;
    if (i_req == 2'b11) begin
      // Contended: favour the requester that did not win last time.
      o_grant = i_last ? 2'b01 : 2'b10;
    end else begin
      o_grant = i_req;
    end
  end
`else
  logic w_unused_last;
  assign w_unused_last = i_last;

  always_comb begin
    o_grant = '0;
    if (i_req[0]) begin
      o_grant = 2'b01;
    end else if (i_req[1]) begin
      o_grant = 2'b10;
    end
  end
`endif

endmodule

// File: rtl/mul_arbiter.sv
// Arbitrates two requesters onto one external multi-cycle multiplier.
// Define MUL_ARB_RR_EN for round-robin arbitration of simultaneous requests.
module mul_arbiter
  import mul_arb_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned MUL_CYCLES = MUL_CYCLES_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0_valid,
  input  logic                 req1_valid,
  output logic                 req0_ready,
  output logic                 req1_ready,
  input  logic [WIDTH-1:0]     req0_a,
  input  logic [WIDTH-1:0]     req0_b,
  input  logic [WIDTH-1:0]     req1_a,
  input  logic [WIDTH-1:0]     req1_b,
  output logic                 resp0_valid,
  output logic                 resp1_valid,
  input  logic                 resp0_ready,
  input  logic                 resp1_ready,
  output logic [2*WIDTH-1:0]   resp_result,
  output logic [WIDTH-1:0]     mul_a,
  output logic [WIDTH-1:0]     mul_b,
  output logic [CNT_W-1:0]     mul_clkcount,
  input  logic [2*WIDTH-1:0]   mul_result
);

  localparam logic [CNT_W-1:0] LP_CNT_MAX = CNT_W'(MUL_CYCLES);

  state_t               r_state;
  state_t               w_next;
  logic                 r_gid;
  logic [CNT_W-1:0]     r_cnt;
  logic [WIDTH-1:0]     r_mul_a;
  logic [WIDTH-1:0]     r_mul_b;
  logic [2*WIDTH-1:0]   r_result;
  logic [1:0]           w_grant;
  logic                 w_last;
  logic                 w_accept;
  logic                 w_sel;
  logic                 w_resp_hs;

`ifdef MUL_ARB_RR_EN
  logic r_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last <= 1'b1;
    end else if (w_accept) begin
      r_last <= w_sel;
    end
  end

  assign w_last = r_last;
`else
  assign w_last = 1'b1;
`endif

  mul_arb_rr u_rr (
    .i_req   ({req1_valid, req0_valid}),
    .i_last  (w_last),
    .o_grant (w_grant)
  );

  assign req0_ready  = (r_state == ST_IDLE) & w_grant[0];
  assign req1_ready  = (r_state == ST_IDLE) & w_grant[1];
  assign w_accept    = req0_ready | req1_ready;
  assign w_sel       = req1_ready;
  assign w_resp_hs   = (r_state == ST_DONE) & (r_gid ? resp1_ready : resp0_ready);

  assign resp0_valid  = (r_state == ST_DONE) & ~r_gid;
  assign resp1_valid  = (r_state == ST_DONE) &  r_gid;
  assign resp_result  = r_result;
  assign mul_a        = r_mul_a;
  assign mul_b        = r_mul_b;
  assign mul_clkcount = r_cnt;

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_accept)             w_next = ST_RUN;
      ST_RUN:  if (r_cnt == LP_CNT_MAX)  w_next = ST_DONE;
      ST_DONE: if (w_resp_hs)            w_next = ST_IDLE;
      default:                           w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Counter saturates at LP_CNT_MAX: the result is captured on that edge and held.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_gid    <= 1'b0;
      r_cnt    <= '0;
      r_mul_a  <= '0;
      r_mul_b  <= '0;
      r_result <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_gid   <= w_sel;
            r_cnt   <= '0;
            r_mul_a <= w_sel ? req1_a : req0_a;
            r_mul_b <= w_sel ? req1_b : req0_b;
          end
        end
        ST_RUN: begin
          if (r_cnt == LP_CNT_MAX) begin
            r_result <= mul_result;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_arbiter.sv
// Directed self-checking bench for mul_arbiter with a behavioural multiplier.
// Expected grant order depends on MUL_ARB_RR_EN.
module tb_mul_arbiter;

  localparam int unsigned W       = 32;
  localparam int unsigned MUL_CYC = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            req0_valid, req1_valid;
  logic            req0_ready, req1_ready;
  logic [W-1:0]    req0_a, req0_b, req1_a, req1_b;
  logic            resp0_valid, resp1_valid;
  logic            resp0_ready, resp1_ready;
  logic [2*W-1:0]  resp_result;
  logic [W-1:0]    mul_a, mul_b;
  logic [5:0]      mul_clkcount;
  logic [2*W-1:0]  mul_result;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Product is only meaningful on the final step; anything earlier is poison.
  assign mul_result = (mul_clkcount == 6'(MUL_CYC)) ?
                      ({32'b0, mul_a} * {32'b0, mul_b}) : 64'hBAD0_BAD0_BAD0_BAD0;

  mul_arbiter #(.WIDTH(W), .MUL_CYCLES(MUL_CYC)) dut (
    .clk          (clk),
    .rst          (rst),
    .req0_valid   (req0_valid),
    .req1_valid   (req1_valid),
    .req0_ready   (req0_ready),
    .req1_ready   (req1_ready),
    .req0_a       (req0_a),
    .req0_b       (req0_b),
    .req1_a       (req1_a),
    .req1_b       (req1_b),
    .resp0_valid  (resp0_valid),
    .resp1_valid  (resp1_valid),
    .resp0_ready  (resp0_ready),
    .resp1_ready  (resp1_ready),
    .resp_result  (resp_result),
    .mul_a        (mul_a),
    .mul_b        (mul_b),
    .mul_clkcount (mul_clkcount),
    .mul_result   (mul_result)
  );

  typedef struct {
    string       name;
    int          id;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Entered just after the accepting edge (at the following negedge).
  task automatic wait_resp(input int id, input logic [63:0] exp, input string nm, input int hold);
    int   lat;
    bit   seen;
    logic [63:0] held;
    seen = 0;
    for (lat = 1; lat <= 100; lat++) begin
      @(negedge clk);
      if ((id == 0) ? resp0_valid : resp1_valid) begin
        seen = 1;
        break;
      end
    end
    check({nm, " latency"}, 64'(lat), 64'(MUL_CYC + 1));
    check({nm, " result"}, resp_result, exp);
    check({nm, " other_valid"}, (id == 0) ? resp1_valid : resp0_valid, 1'b0);
    check({nm, " clkcount"}, 64'(mul_clkcount), 64'(MUL_CYC));
    if (hold > 0) begin
      held = resp_result;
      req1_valid  = 1'b1;
      resp1_ready = 1'b1;
      for (int k = 0; k < hold; k++) begin
        @(negedge clk);
        check({nm, " hold_valid"}, resp0_valid, 1'b1);
        check({nm, " hold_result"}, resp_result, held);
        check({nm, " hold_cnt"}, 64'(mul_clkcount), 64'(MUL_CYC));
        check({nm, " hold_req1_ready"}, req1_ready, 1'b0);
      end
      req1_valid  = 1'b0;
      resp1_ready = 1'b0;
    end
    if (id == 0) resp0_ready = 1'b1; else resp1_ready = 1'b1;
    @(negedge clk);
    resp0_ready = 1'b0;
    resp1_ready = 1'b0;
    check({nm, " valid_drop"}, {resp1_valid, resp0_valid}, 2'b00);
    if (seen == 0) $display("FAIL %s timeout actual=none required=resp", nm);
  endtask

  task automatic issue(input int id, input logic [31:0] a, input logic [31:0] b, input string nm);
    if (id == 0) begin
      req0_valid = 1'b1; req0_a = a; req0_b = b;
    end else begin
      req1_valid = 1'b1; req1_a = a; req1_b = b;
    end
    #1;
    check({nm, " ready"}, {req1_ready, req0_ready}, (id == 0) ? 2'b01 : 2'b10);
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    check({nm, " mul_a"}, mul_a, a);
    check({nm, " mul_b"}, mul_b, b);
    check({nm, " cnt0"}, 64'(mul_clkcount), 64'd0);
  endtask

  task automatic do_single(input int id, input logic [31:0] a, input logic [31:0] b,
                           input logic [63:0] exp, input string nm, input int hold);
    issue(id, a, b, nm);
    wait_resp(id, exp, nm, hold);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int  g;
    int  found;
    int  stray;
    logic [63:0] exp_b;

    vecs[0] = '{"r0_15x3",  0, 32'd15,        32'd3,        64'h2D};
    vecs[1] = '{"r1_16x4",  1, 32'd16,        32'd4,        64'h40};
    vecs[2] = '{"r0_max",   0, 32'hFFFFFFFF,  32'hFFFFFFFF, 64'hFFFFFFFE_00000001};
    vecs[3] = '{"r1_mix",   1, 32'h12345678,  32'd9,        64'hA3D70A38};
    vecs[4] = '{"r0_zero",  0, 32'd0,         32'hDEADBEEF, 64'h0};

    rst = 1'b1;
    req0_valid = 0; req1_valid = 0;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    resp0_ready = 0; resp1_ready = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    check("reset resp_valid", {resp1_valid, resp0_valid}, 2'b00);
    check("reset cnt", 64'(mul_clkcount), 64'd0);
    check("reset mul_ab", {mul_a, mul_b}, 64'd0);
    check("reset result", resp_result, 64'd0);
    check("reset req_ready", {req1_ready, req0_ready}, 2'b00);

    for (int i = 0; i < 5; i++) begin
      do_single(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].name, 0);
    end

    // Simultaneous requests from a freshly reset pointer.
    pulse_reset();
    for (int r = 0; r < 3; r++) begin
`ifdef MUL_ARB_RR_EN
      g = r % 2;
`else
      g = 0;
`endif
      req0_valid = 1'b1; req0_a = 32'd5 + 32'(r); req0_b = 32'd2;
      req1_valid = 1'b1; req1_a = 32'd100 + 32'(r); req1_b = 32'd3;
      #1;
      check($sformatf("both r%0d grant", r), {req1_ready, req0_ready}, (g == 0) ? 2'b01 : 2'b10);
      @(negedge clk);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      exp_b = (g == 0) ? 64'(2 * (5 + r)) : 64'(3 * (100 + r));
      wait_resp(g, exp_b, $sformatf("both r%0d", r), 0);
    end

    // Back-pressure on the response with foreign traffic present.
    do_single(0, 32'h1234, 32'h10, 64'h12340, "hold", 10);

    // Reset mid-operation drops the job.
    issue(0, 32'd11, 32'd13, "rst_mid");
    found = 0;
    for (int k = 0; k < 50; k++) begin
      if (mul_clkcount == 6'd12) begin
        found = 1;
        break;
      end
      @(negedge clk);
    end
    check("rst_mid reach12", 64'(found), 64'd1);
    pulse_reset();
    check("rst_mid resp_valid", {resp1_valid, resp0_valid}, 2'b00);
    check("rst_mid cnt", 64'(mul_clkcount), 64'd0);
    check("rst_mid mul_ab", {mul_a, mul_b}, 64'd0);
    check("rst_mid result", resp_result, 64'd0);
    check("rst_mid req_ready", {req1_ready, req0_ready}, 2'b00);
    stray = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (resp0_valid || resp1_valid) stray++;
    end
    check("rst_mid no_resp", 64'(stray), 64'd0);
    do_single(0, 32'd7, 32'd9, 64'h3F, "post_rst_7x9", 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mul_arbiter.md
MUL_ARBITER -- requirements
Module: mul_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand width.
REQ-002 The block SHALL have parameter MUL_CYCLES, default 32, giving the clkcount value at which the multiplier result is valid.
REQ-003 The block SHALL have ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- req0_valid, req1_valid  input  1  operand request.
- req0_ready, req1_ready  output  1  request accepted this cycle.
- req0_a, req0_b, req1_a, req1_b  input  WIDTH  operands.
- resp0_valid, resp1_valid  output  1  result available.
- resp0_ready, resp1_ready  input  1  result consumed.
- resp_result  output  2*WIDTH  product, shared by both responders.
- mul_a, mul_b  output  WIDTH  operands to the shared multiplier.
- mul_clkcount  output  6  step counter to the multiplier.
- mul_result  input  2*WIDTH  multiplier product.
REQ-004 The block SHALL have one clock, clk; reset rst SHALL be synchronous and active-high.

Function
REQ-005 The FSM SHALL have three states:
- IDLE -> RUN on a request handshake.
- RUN -> DONE when mul_clkcount == MUL_CYCLES.
- DONE -> IDLE on the response handshake of the granted requester.
REQ-006 reqN_ready SHALL be combinational: high only in IDLE, and only for the requester selected by arbitration that cycle; at most one reqN_ready SHALL be high per cycle.
REQ-007 On a handshake at edge T, the block SHALL latch the operands into mul_a/mul_b, latch the grant id, and set mul_clkcount=0.
REQ-008 In RUN, mul_clkcount SHALL increment by 1 per cycle; it SHALL never exceed MUL_CYCLES and SHALL hold its value in DONE.
REQ-009 At the edge where mul_clkcount==MUL_CYCLES in RUN, the block SHALL capture mul_result into resp_result; respN_valid SHALL then assert at T+MUL_CYCLES+1 (33 cycles after acceptance at default).
REQ-010 respN_valid SHALL be high only in DONE and only for the granted N; it and resp_result SHALL remain stable until respN_ready is sampled high.
REQ-011 mul_a/mul_b SHALL hold constant from acceptance until return to IDLE.
REQ-012 respN_ready for the non-granted requester SHALL be ignored; reqN_valid while not IDLE SHALL be ignored, with no queuing.
REQ-013 After a response handshake, the earliest next acceptance SHALL be the following cycle; IDLE is mandatory for one cycle.
REQ-014 When exactly one request is valid in IDLE, it SHALL be granted regardless of the arbitration policy.

Reset
REQ-015 On rst the block SHALL set state=IDLE, mul_clkcount=0, mul_a=mul_b=0, resp_result=0, respN_valid=0, and the last-grant pointer=1 (req0 preferred), overriding any operation in progress.
REQ-016 An operation in progress when rst is asserted SHALL be dropped silently and SHALL produce no response.

Configuration
REQ-017 With MUL_ARB_RR_EN defined, simultaneous requests SHALL be granted to the requester not granted last, and the pointer SHALL update on every accepted request.
REQ-018 Without MUL_ARB_RR_EN, req0 SHALL always win simultaneous requests (fixed priority), and the pointer logic SHALL be absent.

Structure
REQ-019 Package mul_arb_pkg SHALL hold the FSM state typedef, MUL_CYCLES_DEFAULT, and the counter-width constant (6).
REQ-020 The two-way grant logic SHALL be a sub-module mul_arb_rr, with requests and last-grant as inputs and a one-hot grant as output; the multiplier itself SHALL remain external.

Verification
REQ-021 The bench SHALL instantiate mul_arbiter with the existing mul block and cover:
- req0 15*3 -> resp0_valid at T+33, resp_result=0x2D.
- req1 16*4 -> resp1_valid, resp_result=0x40; resp0_valid stays 0.
- Both valid in the same cycle:
  - With RR_EN, grants alternate 0,1,0 across three back-to-back rounds.
  - Without RR_EN, req0 is always granted.
- resp0_ready held low 10 cycles after valid -> resp_result and valid are stable, mul_clkcount holds 32, req1_ready stays 0.
- rst asserted at mul_clkcount=12 -> next cycle IDLE, all outputs 0; a new request of 7*9 returns 0x3F.
- 0xFFFFFFFF*0xFFFFFFFF -> resp_result=0xFFFFFFFE00000001.
